// File: rtl/touch_led_mode_ctrl.sv
// -----------------------------------------------------------------------------
// touch_led_mode_ctrl
//
// Mode controller for the capacitive touch key and the single board LED.
// The raw active-low key is synchronised (2 FFs), debounced, and each accepted
// press is classified as short or long. Short presses step the LED mode
// OFF -> ON -> BLINK_SLOW -> BLINK_FAST -> OFF; a long press forces OFF.
//
// Optional feature (compile-time macro TOUCH_AUTO_OFF_EN):
//   when defined, an idle counter returns the LED to OFF after AUTO_OFF_CNT
//   cycles without touch activity. When undefined the mode persists forever
//   and AUTO_OFF_CNT is unused.
//
// Ports:
//   sys_clk    in   system clock, single domain
//   sys_rst_n  in   asynchronous active-low reset
//   touch_key  in   raw touch key, asynchronous, 0 = touched
//   led_out    out  LED drive, active-low (1 = dark), registered
//   mode       out  current mode: 0 OFF, 1 ON, 2 BLINK_SLOW, 3 BLINK_FAST
//   long_press out  one-cycle pulse when a press is classified long
// -----------------------------------------------------------------------------
module touch_led_mode_ctrl #(
  parameter logic [19:0] DEB_CNT      = 20'd500_000,
  parameter logic [25:0] LONG_CNT     = 26'd50_000_000,
  parameter logic [24:0] SLOW_HALF    = 25'd25_000_000,
  parameter logic [24:0] FAST_HALF    = 25'd5_000_000,
  parameter logic [31:0] AUTO_OFF_CNT = 32'd500_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       touch_key,
  output logic       led_out,
  output logic [1:0] mode,
  output logic       long_press
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_HELD
  } press_state_t;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_ON   = 2'd1,
    MODE_SLOW = 2'd2,
    MODE_FAST = 2'd3
  } mode_t;

  // ---------------------------------------------------------------------------
  // Synchroniser: both stages reset to 1 so a reset looks like "released".
  // ---------------------------------------------------------------------------
  logic key_meta;
  logic key_s;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, exactly like real flops.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_meta <= 1'b1;
      key_s    <= 1'b1;
    end else begin
      key_meta <= touch_key;
      key_s    <= key_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: key_d follows key_s only after DEB_CNT consecutive differing
  // cycles; any return to the accepted level restarts the count.
  // ---------------------------------------------------------------------------
  logic        key_d;
  logic [19:0] deb_cnt;
  logic        deb_accept;

  assign deb_accept = (key_s != key_d) && (deb_cnt == DEB_CNT - 20'd1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_d   <= 1'b1;
      deb_cnt <= '0;
    end else if (key_s == key_d) begin
      deb_cnt <= '0;
    end else if (deb_accept) begin
      key_d   <= key_s;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 20'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Press classifier. Events are registered, so the mode register reacts one
  // cycle after the FSM decides. hold_cnt stops at LONG_CNT-1 (saturates) and
  // the HELD state swallows the release of a long press.
  // ---------------------------------------------------------------------------
  press_state_t state, state_nxt;
  logic [25:0]  hold_cnt, hold_nxt;
  logic         short_evt, short_nxt;
  logic         long_nxt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      short_evt  <= 1'b0;
      long_press <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      short_evt  <= short_nxt;
      long_press <= long_nxt;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!key_d) begin
          state_nxt = ST_PRESS;
          hold_nxt  = '0;
        end
      end
      ST_PRESS: begin
        // Reaching the threshold wins over a release seen in the same cycle.
        if (hold_cnt == LONG_CNT - 26'd1) begin
          long_nxt  = 1'b1;
          state_nxt = ST_HELD;
        end else if (key_d) begin
          short_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          hold_nxt = hold_cnt + 26'd1;
        end
      end
      ST_HELD: begin
        if (key_d) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Mode selection. Short event has priority over everything else.
  // ---------------------------------------------------------------------------
  mode_t mode_q, mode_nxt;
  logic  mode_chg;
  logic  timeout;

  always_comb begin
    mode_nxt = mode_q;
    if (short_evt) begin
      mode_nxt = mode_t'(mode_q + 2'd1);
    end else if (long_press || timeout) begin
      mode_nxt = MODE_OFF;
    end
  end

  assign mode_chg = (mode_nxt != mode_q);
  assign mode     = mode_q;

  // ---------------------------------------------------------------------------
  // LED generation. A mode change restarts the blink counter and loads the
  // new mode's initial level, so each blink mode opens with a full lit half.
  // ---------------------------------------------------------------------------
  logic [24:0] half;
  logic [24:0] blink_cnt;

  assign half = (mode_q == MODE_FAST) ? FAST_HALF : SLOW_HALF;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q    <= MODE_OFF;
      led_out   <= 1'b1;
      blink_cnt <= '0;
    end else begin
      mode_q <= mode_nxt;
      if (mode_chg) begin
        blink_cnt <= '0;
        led_out   <= (mode_nxt == MODE_OFF);
      end else if (mode_q == MODE_SLOW || mode_q == MODE_FAST) begin
        if (blink_cnt == half - 25'd1) begin
          blink_cnt <= '0;
          led_out   <= ~led_out;
        end else begin
          blink_cnt <= blink_cnt + 25'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional idle timeout.
  // ---------------------------------------------------------------------------
`ifdef TOUCH_AUTO_OFF_EN
  logic [31:0] idle_cnt;
  logic        idle_run;

  assign idle_run = (mode_q != MODE_OFF) && (state == ST_IDLE);
  assign timeout  = idle_run && (idle_cnt == AUTO_OFF_CNT - 32'd1);

  // The timeout itself is a mode change, so the counter clears on expiry.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idle_cnt <= '0;
    end else if (deb_accept || mode_chg) begin
      idle_cnt <= '0;
    end else if (idle_run) begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  assign timeout = 1'b0;

  logic unused_auto_off;
  assign unused_auto_off = ^AUTO_OFF_CNT;
`endif

endmodule

// File: tb/tb_touch_led_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_touch_led_mode_ctrl
//
// Bench for touch_led_mode_ctrl with small timing parameters. A behavioural
// model (sample delay line, run-length debounce, press age, mode arithmetic,
// LED level derived from time since the last mode change) is compared with
// the DUT every cycle; directed sections add hand-computed expectations.
// Build with +define+TOUCH_AUTO_OFF_EN to exercise the idle timeout.
// -----------------------------------------------------------------------------
module tb_touch_led_mode_ctrl;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int SLOW = 8;
  localparam int FAST = 4;
  localparam int AUTO = 50;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       touch_key = 1'b1;
  logic       led_out;
  logic [1:0] mode;
  logic       long_press;

  int checks   = 0;
  int errors   = 0;
  int lp_count = 0;
  bit cmp_en   = 1'b0;

  touch_led_mode_ctrl #(
    .DEB_CNT     (20'd4),
    .LONG_CNT    (26'd20),
    .SLOW_HALF   (25'd8),
    .FAST_HALF   (25'd4),
    .AUTO_OFF_CNT(32'd50)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .touch_key (touch_key),
    .led_out   (led_out),
    .mode      (mode),
    .long_press(long_press)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit m_meta = 1'b1, m_ks = 1'b1, m_kd = 1'b1;
  int m_run = 0;
  int m_age = -1;          // cycles since the press was accepted, -1 when idle
  bit m_long_done = 1'b0;  // press already classified long
  bit m_short = 1'b0, m_long = 1'b0;
  int m_mode = 0;
  int m_phase = 0;         // cycles since the last mode change
  int m_idle = 0;

  bit n_kd, n_ld, n_short, n_long, tmo;
  int n_run, n_age, n_mode, n_idle;

  function automatic bit exp_led(input int md, input int ph);
    if (md == 0) return 1'b1;
    if (md == 1) return 1'b0;
    return ((ph / ((md == 3) ? FAST : SLOW)) % 2) != 0;
  endfunction

  always @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      m_meta = 1'b1; m_ks = 1'b1; m_kd = 1'b1; m_run = 0;
      m_age = -1; m_long_done = 1'b0; m_short = 1'b0; m_long = 1'b0;
      m_mode = 0; m_phase = 0; m_idle = 0;
    end else begin
      // debounce: accept after DEB consecutive differing samples
      n_kd  = m_kd;
      n_run = 0;
      if (m_ks != m_kd) begin
        if (m_run + 1 == DEB) n_kd = m_ks;
        else n_run = m_run + 1;
      end
      // press classification on the accepted level
      n_age = m_age; n_ld = m_long_done; n_short = 1'b0; n_long = 1'b0;
      if (m_age < 0) begin
        if (!m_kd) begin n_age = 0; n_ld = 1'b0; end
      end else if (!m_long_done) begin
        if (m_age == LONG - 1) begin n_long = 1'b1; n_ld = 1'b1; end
        else if (m_kd) begin n_short = 1'b1; n_age = -1; end
        else n_age = m_age + 1;
      end else if (m_kd) begin
        n_age = -1;
      end
`ifdef TOUCH_AUTO_OFF_EN
      tmo = (m_idle == AUTO - 1) && (m_mode != 0) && (m_age < 0);
`else
      tmo = 1'b0;
`endif
      if (m_short) n_mode = (m_mode + 1) % 4;
      else if (m_long || tmo) n_mode = 0;
      else n_mode = m_mode;
      if (n_kd != m_kd || n_mode != m_mode) n_idle = 0;
      else if (m_mode != 0 && m_age < 0) n_idle = m_idle + 1;
      else n_idle = m_idle;

      m_phase = (n_mode != m_mode) ? 0 : m_phase + 1;
      m_ks = m_meta; m_meta = touch_key;
      m_kd = n_kd; m_run = n_run;
      m_age = n_age; m_long_done = n_ld; m_short = n_short; m_long = n_long;
      m_mode = n_mode; m_idle = n_idle;
    end
  end

  // pulse counter samples the value registered on the previous edge
  always @(posedge sys_clk) if (long_press === 1'b1) lp_count++;

  always @(negedge sys_clk) begin
    if (sys_rst_n && cmp_en) begin
      check("mode", {30'd0, mode}, m_mode);
      check("led_out", {31'd0, led_out}, {31'd0, exp_led(m_mode, m_phase)});
      check("long_press", {31'd0, long_press}, {31'd0, m_long});
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  // Press 10 cycles, release, and return on the negedge where mode changed.
  task automatic short_press(output int lat);
    logic [1:0] old;
    touch_key = 1'b0;
    repeat (10) @(negedge sys_clk);
    old = mode;
    touch_key = 1'b1;
    lat = 0;
    while (mode == old && lat < 20) begin
      @(negedge sys_clk);
      lat++;
    end
  endtask

  task automatic blink_runs(output int low_run, output int high_run);
    low_run = 0;
    high_run = 0;
    while (led_out == 1'b0 && low_run < 40) begin low_run++; @(negedge sys_clk); end
    while (led_out == 1'b1 && high_run < 40) begin high_run++; @(negedge sys_clk); end
  endtask

  initial begin
    int lat, lo, hi, lp0, n, dur;

    repeat (3) @(negedge sys_clk);
    check("reset_mode", {30'd0, mode}, 0);
    check("reset_led", {31'd0, led_out}, 1);
    check("reset_long_press", {31'd0, long_press}, 0);
    sys_rst_n = 1'b1;
    cmp_en = 1'b1;

    lp0 = lp_count;
    repeat (100) @(negedge sys_clk);
    check("idle_led", {31'd0, led_out}, 1);
    check("idle_mode", {30'd0, mode}, 0);
    check("idle_no_long", lp_count - lp0, 0);

    for (int i = 0; i < 4; i++) begin
      short_press(lat);
      check("short_latency", lat, 8);
      check("short_mode", {30'd0, mode}, (i + 1) % 4);
      repeat (10) @(negedge sys_clk);
    end

    for (int i = 0; i < 5; i++) begin
      touch_key = 1'b0;
      repeat (3) @(negedge sys_clk);
      touch_key = 1'b1;
      repeat (10) @(negedge sys_clk);
    end
    check("glitch_mode", {30'd0, mode}, 0);
    check("glitch_key_d", {31'd0, dut.key_d}, 1);

    short_press(lat);
    repeat (5) @(negedge sys_clk);
    short_press(lat);
    check("to_slow", {30'd0, mode}, 2);
    blink_runs(lo, hi);
    check("slow_lit_run", lo, SLOW);
    check("slow_dark_run", hi, SLOW);
    short_press(lat);
    check("to_fast", {30'd0, mode}, 3);
    check("fast_lit_on_change", {31'd0, led_out}, 0);
    blink_runs(lo, hi);
    check("fast_lit_run", lo, FAST);
    check("fast_dark_run", hi, FAST);
    short_press(lat);
    check("wrap_to_off", {30'd0, mode}, 0);
    repeat (5) @(negedge sys_clk);

    short_press(lat);
    repeat (5) @(negedge sys_clk);
    short_press(lat);
    check("long_from_slow", {30'd0, mode}, 2);
    lp0 = lp_count;
    touch_key = 1'b0;
    repeat (40) @(negedge sys_clk);
    check("long_pulse_count", lp_count - lp0, 1);
    check("long_mode", {30'd0, mode}, 0);
    check("long_led", {31'd0, led_out}, 1);
    touch_key = 1'b1;
    repeat (20) @(negedge sys_clk);
    check("long_release_mode", {30'd0, mode}, 0);
    check("long_release_count", lp_count - lp0, 1);

    short_press(lat);
    check("auto_start_mode", {30'd0, mode}, 1);
`ifdef TOUCH_AUTO_OFF_EN
    n = 0;
    while (mode == 2'd1 && n < 1100) begin @(negedge sys_clk); n++; end
    check("auto_off_cycles", n, AUTO);
    check("auto_off_led", {31'd0, led_out}, 1);
`else
    repeat (1000) @(negedge sys_clk);
    check("persist_mode", {30'd0, mode}, 1);
    check("persist_led", {31'd0, led_out}, 0);
`endif

    // reset while the key is held; the key then needs a fresh debounce
    touch_key = 1'b0;
    repeat (15) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check("midpress_reset_mode", {30'd0, mode}, 0);
    check("midpress_reset_led", {31'd0, led_out}, 1);
    sys_rst_n = 1'b1;
    repeat (12) @(negedge sys_clk);
    touch_key = 1'b1;
    repeat (20) @(negedge sys_clk);

    // randomized stimulus, checked every cycle against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
      end
      touch_key = ($urandom_range(0, 4) == 0) ? touch_key : ~touch_key;
      case ($urandom_range(0, 5))
        0:       dur = $urandom_range(1, 4);
        1:       dur = $urandom_range(40, 90);
        default: dur = $urandom_range(5, 35);
      endcase
      repeat (dur) @(negedge sys_clk);
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/touch_led_mode_ctrl.md
Name: touch_led_mode_ctrl

Overview:
Mode controller for the board's capacitive touch key and single LED. It synchronises and debounces the active-low touch input and classifies each touch as short or long. It sequences the LED through four modes: OFF, ON, BLINK_SLOW, BLINK_FAST. It replaces the plain toggle-on-touch path and drives the LED pin directly.

Parameters:
- DEB_CNT, 20'd500_000, cycles the synchronised key must stay stable to accept a level change (10 ms @ 50 MHz).
- LONG_CNT, 26'd50_000_000, cycles of accepted press before the press is classified long (1 s).
- SLOW_HALF, 25'd25_000_000, BLINK_SLOW half-period in cycles.
- FAST_HALF, 25'd5_000_000, BLINK_FAST half-period in cycles.
- AUTO_OFF_CNT, 32'd500_000_000, idle timeout in cycles; used only with TOUCH_AUTO_OFF_EN.

Ports:
- sys_clk  input  1  system clock; single clock domain.
- sys_rst_n  input  1  asynchronous active-low reset.
- touch_key  input  1  raw touch key, asynchronous; 0 = touched.
- led_out  output  1  LED drive, active-low; 1 = dark.
- mode  output  2  current mode: 0 OFF, 1 ON, 2 BLINK_SLOW, 3 BLINK_FAST.
- long_press  output  1  one-cycle pulse when a press crosses LONG_CNT.

Behaviour:
- Reset (async, sys_rst_n=0): synchroniser FFs = 1, debounced key = 1 (released), press FSM = IDLE, all counters = 0, mode = 0, led_out = 1, long_press = 0.
- Reset mid-press forces the IDLE state. A key held through reset release needs a full debounce before it is accepted as a press.
- Synchroniser: 2 FFs on touch_key, producing key_s.
- Debounce: counter clears whenever key_s equals the debounced level. When key_s differs for DEB_CNT consecutive cycles, the debounced level takes key_s and the counter clears. A glitch shorter than DEB_CNT has no effect.
- Press FSM, on the debounced level key_d:
  - IDLE: key_d falls -> PRESS, hold_cnt = 0.
  - PRESS: hold_cnt increments each cycle.
    - key_d rises before hold_cnt reaches LONG_CNT-1 -> short event, then IDLE.
    - hold_cnt reaches LONG_CNT-1 -> long event, long_press = 1 for that cycle, then HELD.
  - HELD: wait for key_d to rise -> IDLE. Releasing a long press produces no further event.
- hold_cnt saturates. A long press produces exactly one long_press pulse.
- Mode update is registered. mode changes on the cycle after the event.
  - Short event: mode = mode+1, wrapping 3 -> 0.
  - Long event: mode = 0 from any mode, including when mode is already 0.
- LED generation:
  - mode 0: led_out = 1.
  - mode 1: led_out = 0.
  - mode 2/3: blink counter counts 0..HALF-1 (SLOW_HALF or FAST_HALF); at HALF-1 it wraps to 0 and led_out toggles.
- On any mode change, the blink counter clears and led_out takes the new mode's initial level (lit for modes 1/2/3), so every blink starts with a full lit half-period.
- led_out is registered and updates on the same cycle as mode.
- Latency from a touch_key edge to the accepted key_d change: 2 + DEB_CNT cycles. A short event follows the release edge by one further cycle, and the mode change by one more.

Optional Feature:
- Macro: TOUCH_AUTO_OFF_EN.
- Defined:
  - An idle counter runs while mode != 0 and the FSM is IDLE.
  - It clears on any accepted key_d edge and on every mode change.
  - On reaching AUTO_OFF_CNT-1: mode = 0, led_out = 1 on the next cycle, counter clears. No long_press pulse is issued.
  - A simultaneous short event takes priority over the timeout.
- Undefined: no idle counter; AUTO_OFF_CNT is unused; mode persists indefinitely.

Test Plan (DEB_CNT=4, LONG_CNT=20, SLOW_HALF=8, FAST_HALF=4, AUTO_OFF_CNT=50):
- Reset then idle 100 cycles -> led_out=1, mode=0, long_press never asserted.
- Four short presses (low 10 cycles, high 10 cycles each) -> mode steps 1, 2, 3, 0. After each press, mode changes exactly 2+4+1+1 cycles after the release edge.
- Glitches low for 3 cycles, repeated 5 times -> no mode change, key_d stays 1.
- From mode 2, hold the key 40 cycles -> one long_press pulse, mode=0, led_out=1. Releasing the key changes nothing.
- mode 2 -> led_out low 8 cycles, high 8, repeating. Short press to mode 3 -> low 4, high 4, starting lit on the change cycle.
- With TOUCH_AUTO_OFF_EN, mode 1 and no touch -> mode=0, led_out=1 after 50 idle cycles. Without the macro, mode stays 1 for 1000 cycles.
